// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode, condition-code, flag and FSM-state types for the pc stage
package cpu_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_RED = 4'h3,
    OP_SLL = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6, OP_PADDSB = 4'h7,
    OP_B = 4'hC, OP_BR = 4'hD, OP_PCS = 4'hE, OP_HLT = 4'hF
  } opcode_e;
  typedef enum logic [2:0] {CC_NE, CC_EQ, CC_GT, CC_LT, CC_GE, CC_LE, CC_OV, CC_UNCOND} cond_e;
  typedef struct packed {logic z; logic v; logic n;} flags_t;
  typedef enum logic {S_RUN, S_HALTED} state_e;
endpackage

// File: rtl/branch_cond.sv
// branch_cond: ccc + registered flags -> met (NE EQ GT LT GE LE OV always)
module branch_cond
  import cpu_pkg::*;
(
  input  cond_e  ccc,
  input  flags_t flags,
  output logic   met
);
  logic [7:0] m;
  assign m = {1'b1, flags.v, flags.z | flags.n, flags.z | !flags.n, flags.n,
              !flags.z & !flags.n, flags.z, !flags.z};
  assign met = m[ccc];
endmodule

// File: rtl/pc_control.sv
// pc_control: PC, Z/V/N flags and halt FSM; in clk rst stall instr alu_z/v/n rs_data, out pc pc_plus2 branch_taken halt align_err; PC_ALIGN_CHECK_EN enables BR target alignment
module pc_control
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [15:0] instr,
  input  logic        alu_z,
  input  logic        alu_v,
  input  logic        alu_n,
  input  logic [15:0] rs_data,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        branch_taken,
  output logic        halt,
  output logic        align_err
);
  opcode_e op;
  flags_t flags_q, flags_d;
  state_e state_q, state_d;
  logic [15:0] pc_q, pc_d, b_target, br_target, target;
  logic align_err_q, align_err_d, met, running, adv;
  assign op = opcode_e'(instr[15:12]);
  branch_cond u_cond (.ccc(cond_e'(instr[11:9])), .flags(flags_q), .met(met));
  assign running = state_q == S_RUN;
  assign adv = running & !stall;
  assign pc_plus2 = pc_q + 16'd2;
  assign b_target = pc_plus2 + {{6{instr[8]}}, instr[8:0], 1'b0};
`ifdef PC_ALIGN_CHECK_EN
  assign br_target = {rs_data[15:1], 1'b0};
`else
  assign br_target = rs_data;
`endif
  assign target = op == OP_BR ? br_target : b_target;
  assign branch_taken = running & (op == OP_B | op == OP_BR) & met;
  always_comb begin
    pc_d = (!adv || op == OP_HLT) ? pc_q : branch_taken ? target : pc_plus2;
    flags_d = !adv ? flags_q
            : (op == OP_ADD || op == OP_SUB) ? flags_t'({alu_z, alu_v, alu_n})
            : (op == OP_XOR || op == OP_SLL || op == OP_SRA || op == OP_ROR) ? flags_t'({alu_z, flags_q.v, flags_q.n})
            : flags_q;
    state_d = (adv && op == OP_HLT) ? S_HALTED : state_q;
`ifdef PC_ALIGN_CHECK_EN
    align_err_d = adv & branch_taken & (op == OP_BR) & rs_data[0];
`else
    align_err_d = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      flags_q <= '0;
      state_q <= S_RUN;
      align_err_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      flags_q <= flags_d;
      state_q <= state_d;
      align_err_q <= align_err_d;
    end
  end
  assign pc = pc_q;
  assign halt = state_q == S_HALTED;
  assign align_err = align_err_q;
endmodule

// File: tb/tb_pc_control.sv
// tb_pc_control: directed and randomized checks of pc_control against a behavioural model
module tb_pc_control;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  logic clk = 0, rst = 1, stall = 0, alu_z = 0, alu_v = 0, alu_n = 0;
  logic [15:0] instr = 16'h8000, rs_data = 0;
  logic [15:0] pc, pc_plus2;
  logic branch_taken, halt, align_err;
  int total = 0, bad = 0;
  logic [15:0] m_pc;
  bit m_z, m_v, m_n, m_halt, m_align;
  pc_control dut (.clk(clk), .rst(rst), .stall(stall), .instr(instr), .alu_z(alu_z),
    .alu_v(alu_v), .alu_n(alu_n), .rs_data(rs_data), .pc(pc), .pc_plus2(pc_plus2),
    .branch_taken(branch_taken), .halt(halt), .align_err(align_err));
  always #5 clk = ~clk;
  function automatic bit cond_ok(input logic [2:0] c);
    case (c)
      0: return !m_z;
      1: return m_z;
      2: return !m_z && !m_n;
      3: return m_n;
      4: return m_z || !m_n;
      5: return m_z || m_n;
      6: return m_v;
      default: return 1;
    endcase
  endfunction
  function automatic bit exp_taken();
    int op = int'(instr[15:12]);
    return !m_halt && (op == 12 || op == 13) && cond_ok(instr[11:9]);
  endfunction
  function automatic logic [15:0] b_tgt();
    int off = instr[8] ? int'(instr[8:0]) - 512 : int'(instr[8:0]);
    return 16'(int'(m_pc) + 2 + 2 * off);
  endfunction
  task automatic model_next();
    int op = int'(instr[15:12]);
    bit tk = exp_taken();
    if (rst) begin
      m_pc = 0; {m_z, m_v, m_n} = 0; m_halt = 0; m_align = 0;
      return;
    end
    m_align = 0;
    if (stall || m_halt) return;
    if (op == 15) m_halt = 1;
    else if (tk && op == 13) begin
      m_pc = ALIGN ? (rs_data & 16'hFFFE) : rs_data;
      m_align = ALIGN && rs_data[0];
    end else if (tk) m_pc = b_tgt();
    else m_pc = 16'(m_pc + 2);
    if (op == 0 || op == 1) {m_z, m_v, m_n} = {alu_z, alu_v, alu_n};
    else if (op == 2 || op == 4 || op == 5 || op == 6) m_z = alu_z;
  endtask
  task automatic apply(input logic [15:0] i, input bit z, v, n, input logic [15:0] rs, input bit st);
    instr = i; alu_z = z; alu_v = v; alu_n = n; rs_data = rs; stall = st;
    #1;
  endtask
  task automatic tick();
    model_next();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1; apply(16'h8000, 0, 0, 0, 0, 0); tick(); rst = 0;
  endtask
  task automatic test_reset();
    do_reset();
    total++; if (pc !== 16'h0000) begin bad++; $display("FAIL reset_pc got=%h exp=0000", pc); end
    total++; if (halt !== 1'b0) begin bad++; $display("FAIL reset_halt got=%b exp=0", halt); end
    total++; if (align_err !== 1'b0) begin bad++; $display("FAIL reset_align got=%b exp=0", align_err); end
    total++; if (pc_plus2 !== 16'h0002) begin bad++; $display("FAIL reset_pc_plus2 got=%h exp=0002", pc_plus2); end
  endtask
  task automatic test_branch_eq();
    apply(16'h0000, 1, 0, 0, 0, 0); tick();
    total++; if (pc !== 16'h0002) begin bad++; $display("FAIL add_pc got=%h exp=0002", pc); end
    apply(16'hC204, 0, 0, 0, 0, 0);
    total++; if (branch_taken !== 1'b1) begin bad++; $display("FAIL beq_taken got=%b exp=1", branch_taken); end
    tick();
    total++; if (pc !== 16'h000C) begin bad++; $display("FAIL beq_pc got=%h exp=000c", pc); end
  endtask
  task automatic test_ne_xor();
    apply(16'hC004, 0, 0, 0, 0, 0);
    total++; if (branch_taken !== 1'b0) begin bad++; $display("FAIL bne_taken got=%b exp=0", branch_taken); end
    tick();
    total++; if (pc !== 16'h000E) begin bad++; $display("FAIL bne_pc got=%h exp=000e", pc); end
    apply(16'h2000, 0, 1, 0, 0, 0); tick();
    apply(16'hCC00, 0, 0, 0, 0, 0);
    total++; if (branch_taken !== 1'b0) begin bad++; $display("FAIL xor_v_held got=%b exp=0", branch_taken); end
    apply(16'hC200, 0, 0, 0, 0, 0);
    total++; if (branch_taken !== 1'b0) begin bad++; $display("FAIL xor_z_clear got=%b exp=0", branch_taken); end
  endtask
  task automatic test_gt();
    apply(16'hC5FE, 0, 0, 0, 0, 0);
    total++; if (branch_taken !== 1'b1) begin bad++; $display("FAIL bgt_taken got=%b exp=1", branch_taken); end
    tick();
    total++; if (pc !== 16'h000E) begin bad++; $display("FAIL bgt_back_pc got=%h exp=000e", pc); end
    apply(16'h1000, 0, 0, 1, 0, 0); tick();
    apply(16'hC5FE, 0, 0, 0, 0, 0); tick();
    total++; if (pc !== 16'h0012) begin bad++; $display("FAIL bgt_n_pc got=%h exp=0012", pc); end
  endtask
  task automatic test_br();
    apply(16'hDE00, 0, 0, 0, 16'h1234, 0); tick();
    total++; if (pc !== 16'h1234) begin bad++; $display("FAIL br_pc got=%h exp=1234", pc); end
    apply(16'hDE00, 0, 0, 0, 16'h1235, 0); tick();
    total++; if (pc !== (ALIGN ? 16'h1234 : 16'h1235)) begin bad++; $display("FAIL br_odd_pc got=%h exp=%h", pc, ALIGN ? 16'h1234 : 16'h1235); end
    total++; if (align_err !== ALIGN) begin bad++; $display("FAIL br_align_err got=%b exp=%b", align_err, ALIGN); end
    apply(16'h8000, 0, 0, 0, 0, 0); tick();
    total++; if (align_err !== 1'b0) begin bad++; $display("FAIL align_pulse_end got=%b exp=0", align_err); end
    apply(16'hDE00, 0, 0, 0, 16'hFFFE, 0); tick();
    apply(16'hE000, 0, 0, 0, 0, 0);
    total++; if (pc_plus2 !== 16'h0000) begin bad++; $display("FAIL wrap_pc_plus2 got=%h exp=0000", pc_plus2); end
    tick();
    total++; if (pc !== 16'h0000) begin bad++; $display("FAIL wrap_pc got=%h exp=0000", pc); end
  endtask
  task automatic test_halt_stall();
    do_reset();
    apply(16'hDE00, 0, 0, 0, 16'h0020, 0); tick();
    for (int k = 0; k < 2; k++) begin
      apply(16'hF000, 0, 0, 0, 0, 1); tick();
      total++; if (pc !== 16'h0020 || halt !== 1'b0) begin bad++; $display("FAIL hlt_stalled pc=%h halt=%b exp=0020/0", pc, halt); end
    end
    apply(16'hF000, 0, 0, 0, 0, 0); tick();
    total++; if (halt !== 1'b1) begin bad++; $display("FAIL hlt_halt got=%b exp=1", halt); end
    for (int k = 0; k < 5; k++) begin
      apply(16'hCE04, 1, 1, 1, 16'h4444, 0);
      total++; if (branch_taken !== 1'b0) begin bad++; $display("FAIL halted_taken got=%b exp=0", branch_taken); end
      tick();
      total++; if (pc !== 16'h0020 || halt !== 1'b1) begin bad++; $display("FAIL halted_hold pc=%h halt=%b exp=0020/1", pc, halt); end
    end
    rst = 1; stall = 1; tick(); rst = 0;
    total++; if (pc !== 16'h0000 || halt !== 1'b0) begin bad++; $display("FAIL halt_rst pc=%h halt=%b exp=0000/0", pc, halt); end
  endtask
  task automatic test_stall();
    do_reset();
    apply(16'hCE04, 0, 0, 0, 0, 1); tick();
    total++; if (pc !== 16'h0000) begin bad++; $display("FAIL stall_b_pc got=%h exp=0000", pc); end
    apply(16'h0000, 0, 0, 1, 0, 1); tick();
    apply(16'hC604, 0, 0, 0, 0, 0);
    total++; if (branch_taken !== 1'b0) begin bad++; $display("FAIL stall_flags_held got=%b exp=0", branch_taken); end
    tick();
    total++; if (pc !== 16'h0002) begin bad++; $display("FAIL stall_after_pc got=%h exp=0002", pc); end
  endtask
  task automatic test_random();
    logic [3:0] ops [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'h8, 4'hC, 4'hC, 4'hD, 4'hE, 4'hF};
    do_reset();
    for (int k = 0; k < 600; k++) begin
      logic [15:0] i = 16'($urandom);
      i[15:12] = ops[$urandom_range(0, 11)];
      if (i[15:12] == 4'hF && $urandom_range(0, 3) != 0) i[15:12] = 4'hC;
      rst = $urandom_range(0, 40) == 0;
      apply(i, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), $urandom_range(0, 7) == 0);
      total++; if (branch_taken !== exp_taken()) begin bad++; $display("FAIL rnd_taken k=%0d got=%b exp=%b", k, branch_taken, exp_taken()); end
      total++; if (pc_plus2 !== 16'(m_pc + 2)) begin bad++; $display("FAIL rnd_pc_plus2 k=%0d got=%h exp=%h", k, pc_plus2, 16'(m_pc + 2)); end
      tick();
      total++; if (pc !== m_pc) begin bad++; $display("FAIL rnd_pc k=%0d got=%h exp=%h", k, pc, m_pc); end
      total++; if (halt !== m_halt) begin bad++; $display("FAIL rnd_halt k=%0d got=%b exp=%b", k, halt, m_halt); end
      total++; if (align_err !== m_align) begin bad++; $display("FAIL rnd_align k=%0d got=%b exp=%b", k, align_err, m_align); end
    end
    rst = 0;
  endtask
  initial begin
    test_reset();
    test_branch_eq();
    test_ne_xor();
    test_gt();
    test_br();
    test_halt_stall();
    test_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_control.md
# pc_control

Program-counter and branch-resolution stage of the single-cycle 16-bit processor. Sits directly upstream of the register file and ALU: it holds the PC that addresses instruction memory and the Z/V/N flag register written from ALU results. It resolves B/BR/PCS/HLT each cycle and produces the next PC, including the halt state.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- stall  in  1  freeze all state (PC, flags, halt FSM) this cycle.
- instr  in  16  instruction currently fetched at pc; [15:12] opcode, [11:9] ccc, [8:0] imm9, [7:4] rs for BR.
- alu_z, alu_v, alu_n  in  1 each  ALU result flags for the current instruction.
- rs_data  in  16  register-file read data of rs (BR target).
- pc  out  16  current PC (registered).
- pc_plus2  out  16  pc + 2 (combinational); PCS writeback value.
- branch_taken  out  1  combinational; current instruction redirects PC.
- halt  out  1  registered; high once HLT retires.
- align_err  out  1  registered one-cycle pulse (see Configuration).

## Operation
- Opcodes: ADD 0000, SUB 0001, XOR 0010, RED 0011, SLL 0100, SRA 0101, ROR 0110, PADDSB 0111, B 1100, BR 1101, PCS 1110, HLT 1111; others are non-control.
- Flag register {Z,V,N}: ADD/SUB write all three from alu_*; XOR/SLL/SRA/ROR write Z only; all other opcodes hold flags.
- Branches use the registered flags (results of earlier instructions), never alu_* of the same cycle.
- Conditions ccc: 000 NE (!Z), 001 EQ (Z), 010 GT (!Z & !N), 011 LT (N), 100 GE (Z | !N), 101 LE (Z | N), 110 OV (V), 111 always.
- B: target = pc_plus2 + (sign-extended imm9 << 1), 16-bit wrap-around, no overflow detection.
- BR: target = rs_data.
- Next PC: rst -> RESET_PC; stall or halted -> pc; HLT -> pc (PC never passes the HLT); taken -> target; else pc_plus2.
- FSM: RUN -> HALTED when HLT is presented in RUN with stall low; HALTED exits only by rst. In HALTED, flags frozen and branch_taken forced 0.
- PCS: no PC effect beyond pc_plus2; pc_plus2 is valid every cycle.

## Timing
- Reset values: pc=RESET_PC, flags=000, FSM=RUN, halt=0, align_err=0.
- Single-cycle: instruction at pc resolved in the same cycle; new pc visible after next rising edge.
- halt rises on the edge that retires HLT; stays high until rst.
- stall and HLT together: stall wins; HLT retires on first unstalled cycle.
- rst with stall, or rst in HALTED: rst wins.
- pc = 16'hFFFE non-branch: next pc = 16'h0000.

## Configuration
- PC_ALIGN_CHECK_EN defined: a taken BR with rs_data[0]=1 loads {rs_data[15:1],1'b0} and pulses align_err for one cycle after the edge.
- Undefined: BR loads rs_data unmodified; align_err tied to 0.

## Structure
- Shared package cpu_pkg: opcode enum, condition-code enum (NE..UNCOND), flag struct {z,v,n}, FSM state enum.
- One sub-module branch_cond: combinational ccc + flags -> condition met; instantiated once in pc_control.

## Test plan
- rst, ADD with alu_z=1 at pc 0x0000 -> pc=0x0002, Z=1; then B EQ imm9=0x004 -> branch_taken=1, pc=0x000C.
- Z=1, B NE imm9=0x004 at 0x000C -> not taken, pc=0x000E; XOR with alu_v=1, alu_z=0 -> V unchanged, Z=0.
- Flags Z=0,N=0, B GT imm9=0x1FE at pc 0x0010 -> pc=0x000E; with N=1 -> pc=0x0012.
- BR ccc=111 rs_data=0x1234 -> pc=0x1234; rs_data=0x1235 with PC_ALIGN_CHECK_EN -> pc=0x1234, align_err pulses 1 cycle; without the macro -> pc=0x1235, align_err=0.
- HLT at 0x0020 with stall=1 for 2 cycles -> pc holds 0x0020, halt=0; stall=0 -> halt=1 next edge, pc stays 0x0020 over 5 further edges; rst -> pc=0x0000, halt=0.
- stall=1 during taken B and during ADD with alu_n=1 -> pc and flags unchanged.
